spi_rx_ip: RTL and testbench
============================

SPI_RX_IP -- requirements
Module: spi_rx_ip

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flops in each input synchronizer (legal 2..4).
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port scl  input  1  SPI clock from master, idle low, asynchronous to clk.
REQ-005 The block SHALL have port sda  input  1  SPI data from master, MSB first, asynchronous to clk.
REQ-006 The block SHALL have port cs  input  1  chip select, active-low, asynchronous to clk.
REQ-007 The block SHALL have port rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-008 The block SHALL have port rx_data  output  8  last completed received byte.
REQ-009 The block SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 The block SHALL have port overrun  output  1  sticky flag: a completed byte was dropped.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse: cs deasserted mid-byte.

Function
REQ-012 scl, sda and cs SHALL each pass through a SYNC_STAGES-deep synchronizer; sda and scl SHALL use equal depth so they stay aligned.
REQ-013 A rising edge of synchronized scl SHALL be detected by comparing it with a one-cycle-delayed copy; only rising edges sample data (mode 0).
REQ-014 The FSM SHALL have states IDLE (synced cs high) and SHIFT (synced cs low); IDLE->SHIFT on synced cs falling, SHIFT->IDLE on synced cs rising.
REQ-015 On entry to SHIFT, the 3-bit bit counter and 8-bit shift register SHALL clear to 0.
REQ-016 In SHIFT, each scl rising edge SHALL shift: shift <= {shift[6:0], sda_sync}, counter +1.
REQ-017 On the 8th edge (counter 7), rx_data SHALL load {shift[6:0], sda_sync} and rx_valid SHALL go 1 on that same clk edge; counter wraps to 0 so consecutive bytes continue while cs low.
REQ-018 Latency: rx_valid SHALL rise SYNC_STAGES+1 clk edges after the first edge that samples the 8th raw scl rise high.
REQ-019 rx_valid SHALL stay 1, with rx_data stable, until a cycle with rx_valid=1 and rx_ready=1; then it clears on the next edge unless REQ-020 applies.
REQ-020 Byte completion in the same cycle as an accepting handshake SHALL load the new byte, keep rx_valid=1 and not set overrun.
REQ-021 Byte completion while rx_valid=1 and rx_ready=0 SHALL drop the new byte, keep the old rx_data and set overrun=1.
REQ-022 overrun SHALL clear only on reset or on the next synced cs falling edge.
REQ-023 scl edges in IDLE SHALL be ignored; cs rising with counter != 0 SHALL discard the partial byte without touching rx_data/rx_valid.
REQ-024 Operation SHALL be correct for scl high and low phases each >= SYNC_STAGES+2 clk cycles.

Reset
REQ-025 On reset: rx_data=0x00, rx_valid=0, overrun=0, frame_err=0, FSM=IDLE, counter=0, shift=0, all synchronizer flops reset to idle values (scl 0, sda 0, cs 1).
REQ-026 Reset asserted mid-byte SHALL abort the byte; after release, a byte is received only after a fresh cs falling edge.

Configuration
REQ-027 Macro SPI_RX_FRAME_ERR_EN: when defined, frame_err SHALL pulse 1 for exactly one clk cycle when synced cs rises with counter != 0; when undefined, frame_err SHALL be tied to 0 and the detection logic is absent.

Verification
REQ-028 cs low, send 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid high one cycle, overrun=0.
REQ-029 One cs frame, send 0x3C then 0xC3 with rx_ready=1 -> two handshakes, data 0x3C then 0xC3, in order.
REQ-030 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, overrun=1; next cs fall clears overrun.
REQ-031 Send 5 bits of 0xFF then raise cs, then a new frame with 0x5A -> no rx_valid for the partial byte, frame_err one pulse (macro defined; 0 otherwise), rx_data=0x5A.
REQ-032 Assert reset after 4 bits of 0x96, release, then send 0x69 in a new frame -> all outputs 0 during reset, then rx_data=0x69.
REQ-033 Toggle scl 8 times with cs high -> rx_valid stays 0, rx_data unchanged.

Source files
------------

// File: rtl/spi_rx_ip.sv
// SPI mode-0 byte receiver with input synchronizers and a valid/ready output handshake.
// Optional macro SPI_RX_FRAME_ERR_EN adds a one-cycle frame_err pulse when cs rises mid-byte.
//   state | meaning
//   IDLE  | synced cs high, scl edges ignored
//   SHIFT | synced cs low, bits shifted on scl rising edges
module spi_rx_ip #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       cs,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_ff, sda_ff, cs_ff;
  logic                   scl_s, sda_s, cs_s;
  logic                   scl_d, cs_d;
  logic                   scl_rise, cs_fall, cs_rise;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic [7:0]             byte_new;
  logic                   frame_start, shift_en, byte_done;

  // scl and sda share the same depth so a sampled bit lines up with its clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_ff <= '0;
      sda_ff <= '0;
      cs_ff  <= '1;
      scl_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
      cs_ff  <= {cs_ff[SYNC_STAGES-2:0], cs};
      scl_d  <= scl_s;
      cs_d   <= cs_s;
    end
  end

  assign scl_s    = scl_ff[SYNC_STAGES-1];
  assign sda_s    = sda_ff[SYNC_STAGES-1];
  assign cs_s     = cs_ff[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign byte_new = {shift_q[6:0], sda_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SPI_RX_FRAME_ERR_EN
  logic partial_abort;
`endif

  always_comb begin
    frame_start = (state == IDLE) && cs_fall;
    shift_en    = (state == SHIFT) && scl_rise;
    byte_done   = shift_en && (bit_cnt == 3'd7);
`ifdef SPI_RX_FRAME_ERR_EN
    partial_abort = (state == SHIFT) && cs_rise && (bit_cnt != 3'd0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
    end else if (frame_start) begin
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift_q <= byte_new;
    end
  end

  // A completing byte wins over a pending one only if the pending byte is being accepted now
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= byte_new;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (frame_start) overrun <= 1'b0;
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= partial_abort;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_ip.sv
// Scoreboard bench for spi_rx_ip: expected bytes are queued as they are sent and
// popped on each rx_valid/rx_ready handshake.
module tb_spi_rx_ip;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl, sda, cs, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err;

  int         n_cmp = 0;
  int         n_err = 0;
  int         valid_cycles = 0;
  int         fe_cycles = 0;
  int         n_hs = 0;
  logic [7:0] sb_q[$];

  spi_rx_ip #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .cs       (cs),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every handshake must match the oldest queued byte
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cycles++;
      if (rx_valid) begin
        valid_cycles++;
        if (rx_ready) begin
          n_hs++;
          chk("sb_nonempty", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) chk("sb_data", rx_data, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send_bits(input logic [7:0] d, input int n, input bit lat);
    for (int i = 0; i < n; i++) begin
      sda = d[7-i];
      repeat (HALF) @(negedge clk);
      scl = 1'b1;
      if (lat && i == n - 1) begin
        repeat (SYNC_STAGES) @(negedge clk);
        chk("lat_early", rx_valid, 0);
        @(negedge clk);
        chk("lat_rise", rx_valid, 1);
        repeat (HALF - SYNC_STAGES - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      scl = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit lat);
    sb_q.push_back(d);
    send_bits(d, 8, lat);
  endtask

  initial begin
    int vc0, fe0, exp_fe;
    scl = 1'b0; sda = 1'b0; cs = 1'b1; rx_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // single byte with latency and one-cycle valid check
    vc0 = valid_cycles;
    cs_low();
    send_byte(8'hA5, 1'b1);
    cs_high();
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid_1cyc", valid_cycles - vc0, 1);
    chk("a5_ovr", overrun, 0);

    // two bytes in one frame
    cs_low();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    cs_high();
    chk("two_hs", n_hs, 3);

    // overrun: second byte dropped while first is pending
    rx_ready = 1'b0;
    cs_low();
    sb_q.push_back(8'h11);
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun, 1);
    cs_high();
    chk("ovr_sticky", overrun, 1);
    cs_low();
    chk("ovr_clear", overrun, 0);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drained", rx_valid, 0);
    cs_high();

    // partial byte then fresh frame
    vc0 = valid_cycles;
    fe0 = fe_cycles;
    cs_low();
    send_bits(8'hFF, 5, 1'b0);
    cs_high();
    chk("part_novalid", valid_cycles - vc0, 0);
`ifdef SPI_RX_FRAME_ERR_EN
    exp_fe = 1;
`else
    exp_fe = 0;
`endif
    chk("part_ferr", fe_cycles - fe0, exp_fe);
    cs_low();
    send_byte(8'h5A, 1'b0);
    cs_high();
    chk("part_next", rx_data, 8'h5A);

    // reset mid-byte
    cs_low();
    send_bits(8'h96, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cs = 1'b1;
    scl = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_ferr", frame_err, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    cs_low();
    send_byte(8'h69, 1'b0);
    cs_high();
    chk("post_rst", rx_data, 8'h69);

    // scl activity with cs high is ignored
    vc0 = valid_cycles;
    send_bits(8'hFF, 8, 1'b0);
    repeat (10) @(negedge clk);
    chk("idle_novalid", valid_cycles - vc0, 0);
    chk("idle_data", rx_data, 8'h69);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    chk("hs_total", n_hs, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
